// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB requester that runs one command at a time through IDLE/SETUP/ACCESS/RESP.
// Optional ACCESS wait-state timeout is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic                      busy_o
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t r_state, w_next;
    logic w_timeout;
    logic w_done;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [31:0] r_pwdata, r_rdata;
    logic r_pwrite, r_err;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_wait;
    assign w_timeout = r_state == ACCESS && !PREADY && r_wait == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_wait <= '0;
        else if (r_state == IDLE && req_valid_i)
            r_wait <= '0;
        else if (r_state == ACCESS && !PREADY)
            r_wait <= w_timeout ? '0 : r_wait + 1'b1;
    end
`else
    // No limit: ACCESS waits for PREADY indefinitely.
    assign w_timeout = TIMEOUT_CYCLES < 0;
`endif
    assign w_done = r_state == ACCESS && (PREADY || w_timeout);
    always_comb begin
        w_next      = r_state;
        req_ready_o = r_state == IDLE;
        busy_o      = r_state != IDLE;
        PSEL        = r_state == SETUP || r_state == ACCESS;
        PENABLE     = r_state == ACCESS;
        rsp_valid_o = r_state == RESP;
        case (r_state)
            IDLE:    w_next = req_valid_i ? SETUP : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = w_done ? RESP : ACCESS;
            RESP:    w_next = rsp_ready_i ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid_i) begin
                r_paddr  <= req_addr_i;
                r_pwdata <= req_wdata_i;
                r_pwrite <= req_write_i;
            end
            // A timeout abort reports an error with zero data.
            if (w_done) begin
                r_rdata <= (PREADY && !r_pwrite) ? PRDATA : '0;
                r_err   <= PREADY ? PSLVERR : 1'b1;
            end
        end
    end
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PWRITE      = r_pwrite;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed and randomized APB transfers against a transaction-level model.
module tb_apb_master_ctrl;
    localparam int AW = 12;
    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [31:0]   req_wdata_i = '0;
    logic          req_write_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE, PSEL, PENABLE;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;
    logic          busy_o;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    apb_master_ctrl #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_write_i(req_write_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One complete transfer: the expected response and timing come from the protocol rules
    // (3 cycles + waits to response, read data or 0 for writes, error = PSLVERR).
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic err, input int hold);
        logic [31:0] exp_rdata;
        exp_rdata = wr ? 32'h0 : rdata;
        chk("idle_ready", req_ready_o, 1);
        chk("idle_busy", busy_o, 0);
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wdata;
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); rsp_ready_i = 1'($urandom);
        step();
        req_valid_i = 1'b0; req_addr_i = AW'($urandom); req_wdata_i = $urandom; req_write_i = 1'($urandom);
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwdata", PWDATA, wdata);
        chk("setup_pwrite", PWRITE, wr);
        chk("setup_ready", req_ready_o, 0);
        PREADY = 1'($urandom);
        step();
        for (int i = 0; i <= waits; i++) begin
            PREADY = (i == waits);
            PRDATA = (i == waits) ? rdata : $urandom;
            PSLVERR = (i == waits) ? err : 1'($urandom);
            rsp_ready_i = 1'($urandom);
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, addr);
            chk("access_pwdata", PWDATA, wdata);
            chk("access_no_rsp", rsp_valid_o, 0);
            step();
        end
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        for (int h = 0; h <= hold; h++) begin
            rsp_ready_i = (h == hold);
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_rdata", rsp_rdata_o, exp_rdata);
            chk("rsp_err", rsp_err_o, err);
            chk("rsp_psel", PSEL, 0);
            chk("rsp_penable", PENABLE, 0);
            chk("rsp_paddr", PADDR, addr);
            chk("rsp_busy", busy_o, 1);
            step();
        end
        rsp_ready_i = 1'b0;
        chk("post_idle_busy", busy_o, 0);
        chk("post_rsp_valid", rsp_valid_o, 0);
        chk("post_paddr", PADDR, addr);
        chk("post_psel", PSEL, 0);
    endtask

    initial begin
        RESET = 1'b1;
        #1;
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_busy", busy_o, 0);
        step(); step();
        RESET = 1'b0;
        chk("rst_release_ready", req_ready_o, 1);

        xfer(1'b1, 12'h000, 32'hA5, 0, 32'hDEADBEEF, 1'b0, 0);
        xfer(1'b0, 12'h014, 32'h0, 3, 32'h60, 1'b0, 1);
        xfer(1'b0, 12'h020, 32'h0, 1, 32'h1234, 1'b1, 5);
        repeat (20)
            xfer(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 6), $urandom,
                 1'($urandom), $urandom_range(0, 3));

        // Command raised while busy must not disturb the running transfer.
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 12'h0AB;
        step();
        req_valid_i = 1'b0;
        step();
        PREADY = 1'b0; req_valid_i = 1'b1; req_addr_i = 12'h0CD;
        repeat (2) begin
            chk("busy_paddr", PADDR, 12'h0AB);
            chk("busy_ready", req_ready_o, 0);
            step();
        end
        PREADY = 1'b1; PRDATA = 32'h77; PSLVERR = 1'b0;
        step();
        req_valid_i = 1'b0; PREADY = 1'b0;
        chk("busy_rsp_rdata", rsp_rdata_o, 32'h77);
        chk("busy_rsp_paddr", PADDR, 12'h0AB);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("busy_back_idle", busy_o, 0);
        step();
        chk("busy_no_late_accept", busy_o, 0);
        chk("busy_final_paddr", PADDR, 12'h0AB);

        // Reset pulsed during an ACCESS wait state.
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 12'h055; req_wdata_i = 32'h5;
        step();
        req_valid_i = 1'b0;
        step();
        PREADY = 1'b0;
        step();
        chk("mid_rst_penable_before", PENABLE, 1);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_psel", PSEL, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_paddr", PADDR, 0);
        step();
        RESET = 1'b0; PREADY = 1'b1;
        repeat (3) begin
            chk("mid_rst_no_rsp", rsp_valid_o, 0);
            chk("mid_rst_ready", req_ready_o, 1);
            step();
        end
        xfer(1'b0, 12'h066, 32'h0, 2, 32'hCAFE0001, 1'b0, 0);

        // PREADY stuck low.
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 12'h0F0;
        step();
        req_valid_i = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF0000;
        step();
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            chk("to_wait_penable", PENABLE, 1);
            chk("to_wait_no_rsp", rsp_valid_o, 0);
            step();
        end
        chk("to_rsp_valid", rsp_valid_o, 1);
        chk("to_psel", PSEL, 0);
        chk("to_err", rsp_err_o, 1);
        chk("to_rdata", rsp_rdata_o, 0);
`else
        repeat (100) step();
        chk("nto_penable", PENABLE, 1);
        chk("nto_no_rsp", rsp_valid_o, 0);
        PREADY = 1'b1; PRDATA = 32'h99;
        step();
        PREADY = 1'b0;
        chk("nto_rsp_valid", rsp_valid_o, 1);
        chk("nto_rdata", rsp_rdata_o, 32'h99);
        chk("nto_err", rsp_err_o, 0);
`endif
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("stuck_end_idle", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
